// File: rtl/aes_128_key_sched_seq.sv
// Iterative AES-128 key expansion: one round key per clock into an 11-entry register file.
// Key-to-ready latency is 10 cycles; registered read port has 1-cycle latency and never stalls.
module aes_128_key_sched_seq (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [127:0] key_i,
  input  logic         key_valid_i,
  output logic         key_ready_o,
  output logic         keys_valid_o,
  input  logic         rk_rd_en_i,
  input  logic [3:0]   rk_idx_i,
  output logic [127:0] rk_data_o,
  output logic         rk_rd_valid_o,
  output logic         rk_rd_err_o
);

  typedef enum logic [1:0] {IDLE, EXPAND, READY} state_t;

  // Forward S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [10:0] top;
    top = {~b, 3'b111};
    return SBOX[top -: 8];
  endfunction

  function automatic logic [31:0] g_function(input logic [31:0] w, input logic [7:0] rcon);
    logic [31:0] rot;
    rot = {w[23:0], w[31:24]};
    return {sbox(rot[31:24]) ^ rcon, sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] r);
    return {r[6:0], 1'b0} ^ (r[7] ? 8'h1b : 8'h00);
  endfunction

  state_t        state_q, state_d;
  logic [127:0]  rk_q [11];
  logic [127:0]  w_q, w_d, w_next;
  logic [3:0]    rnd_q, rnd_d;
  logic [7:0]    rcon_q, rcon_d;
  logic          rk_we;
  logic [3:0]    rk_waddr;
  logic [127:0]  rk_wdata;
  logic [127:0]  rk_data_q, rk_data_d;
  logic          rk_rd_valid_q, rk_rd_err_q;
  logic          rd_ok;
  logic [31:0]   w4, w5, w6, w7;

  assign key_ready_o   = (state_q != EXPAND);
  assign keys_valid_o  = (state_q == READY);
  assign rk_data_o     = rk_data_q;
  assign rk_rd_valid_o = rk_rd_valid_q;
  assign rk_rd_err_o   = rk_rd_err_q;

  assign w4     = w_q[127:96] ^ g_function(w_q[31:0], rcon_q);
  assign w5     = w_q[95:64] ^ w4;
  assign w6     = w_q[63:32] ^ w5;
  assign w7     = w_q[31:0] ^ w6;
  assign w_next = {w4, w5, w6, w7};

  always_comb begin
    state_d  = state_q;
    w_d      = w_q;
    rnd_d    = rnd_q;
    rcon_d   = rcon_q;
    rk_we    = 1'b0;
    rk_waddr = 4'd0;
    rk_wdata = '0;
    case (state_q)
      IDLE, READY: begin
        if (key_valid_i) begin
          state_d  = EXPAND;
          w_d      = key_i;
          rnd_d    = 4'd1;
          rcon_d   = 8'h01;
          rk_we    = 1'b1;
          rk_wdata = key_i;
        end
      end
      EXPAND: begin
        w_d      = w_next;
        rk_we    = 1'b1;
        rk_waddr = rnd_q;
        rk_wdata = w_next;
        rnd_d    = rnd_q + 4'd1;
        rcon_d   = xtime(rcon_q);
        if (rnd_q == 4'd10) state_d = READY;
      end
      default: state_d = IDLE;
    endcase
  end

  // Reads see the register file as it was before this edge, even when it is being rewritten.
  assign rd_ok     = rk_rd_en_i && keys_valid_o && (rk_idx_i <= 4'd10);
  assign rk_data_d = rd_ok ? rk_q[rk_idx_i] : rk_data_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < 11; i++) rk_q[i] <= '0;
      w_q           <= '0;
      rnd_q         <= '0;
      rcon_q        <= '0;
      rk_data_q     <= '0;
      rk_rd_valid_q <= 1'b0;
      rk_rd_err_q   <= 1'b0;
    end else begin
      if (rk_we) rk_q[rk_waddr] <= rk_wdata;
      w_q           <= w_d;
      rnd_q         <= rnd_d;
      rcon_q        <= rcon_d;
      rk_data_q     <= rk_data_d;
      rk_rd_valid_q <= rd_ok;
      rk_rd_err_q   <= rk_rd_en_i && !rd_ok;
    end
  end

endmodule

// File: tb/tb_aes_128_key_sched_seq.sv
// Directed + randomized bench for aes_128_key_sched_seq against a FIPS-197 style word-expansion model
// whose S-box is derived from GF(2^8) inversion and the affine transform.
module tb_aes_128_key_sched_seq;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [127:0] key;
  logic         key_valid;
  logic         key_ready;
  logic         keys_valid;
  logic         rk_rd_en;
  logic [3:0]   rk_idx;
  logic [127:0] rk_data;
  logic         rk_rd_valid;
  logic         rk_rd_err;

  int vecs  = 0;
  int fails = 0;

  logic [7:0]   sbox_m [256];
  logic [7:0]   rcon_m [11];
  logic [127:0] exp_rk [11];
  logic [127:0] exp_data;

  always #5 clk = ~clk;

  aes_128_key_sched_seq dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .key_i        (key),
    .key_valid_i  (key_valid),
    .key_ready_o  (key_ready),
    .keys_valid_o (keys_valid),
    .rk_rd_en_i   (rk_rd_en),
    .rk_idx_i     (rk_idx),
    .rk_data_o    (rk_data),
    .rk_rd_valid_o(rk_rd_valid),
    .rk_rd_err_o  (rk_rd_err)
  );

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  task automatic build_tables();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
    rcon_m[0] = 8'h00;
    rcon_m[1] = 8'h01;
    for (int i = 2; i < 11; i++) rcon_m[i] = gmul(rcon_m[i-1], 8'h02);
  endtask

  task automatic model_expand(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] t;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_m[t[31:24]], sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]]};
        t = t ^ {rcon_m[i/4], 24'h0};
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vecs++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept a key, then verify keys_valid rises exactly 10 edges after the accept edge.
  task automatic load_key(input logic [127:0] k);
    int n = 0;
    while (!key_ready && n < 20) begin tick(); n++; end
    chk("key_ready_wait", key_ready, 1);
    key = k;
    key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
    chk("busy_after_accept", {keys_valid, key_ready}, 2'b00);
    for (int c = 1; c <= 10; c++) begin
      tick();
      chk("keys_valid_timing", keys_valid, (c == 10) ? 1 : 0);
    end
    chk("key_ready_after", key_ready, 1);
    model_expand(k);
  endtask

  task automatic read_all();
    for (int i = 0; i < 11; i++) begin
      rk_rd_en = 1'b1;
      rk_idx   = 4'(i);
      tick();
      chk("rd_flags", {rk_rd_valid, rk_rd_err}, 2'b10);
      chk("rd_data", rk_data, exp_rk[i]);
      exp_data = exp_rk[i];
    end
    rk_rd_en = 1'b0;
  endtask

  task automatic read_err(input logic [3:0] idx, input string tag);
    rk_rd_en = 1'b1;
    rk_idx   = idx;
    tick();
    rk_rd_en = 1'b0;
    chk(tag, {rk_rd_valid, rk_rd_err}, 2'b01);
    chk("err_data_hold", rk_data, exp_data);
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    logic [127:0] k1, k2, old10;
    rst_n = 1'b0; key = '0; key_valid = 1'b0; rk_rd_en = 1'b0; rk_idx = '0;
    exp_data = '0;
    build_tables();
    tick(); tick();
    chk("reset_flags", {key_ready, keys_valid, rk_rd_valid, rk_rd_err}, 4'b1000);
    chk("reset_data", rk_data, '0);
    rst_n = 1'b1;
    tick();
    read_err(4'd0, "read_idle_err");

    // FIPS-197 key, with literal golden values as well as the model.
    load_key(128'h2b7e151628aed2a6abf7158809cf4f3c);
    chk("fips_model_rk1", exp_rk[1], 128'ha0fafe1788542cb123a339392a6c7605);
    read_all();
    chk("fips_rk10", rk_data, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    load_key(128'h0);
    chk("zero_model_rk1", exp_rk[1], 128'h62636363626363636263636362636363);
    read_all();
    chk("zero_rk10", rk_data, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

    // key_valid held high through EXPAND with a different key, plus a read while busy.
    k1 = rand128();
    k2 = rand128();
    key = k1; key_valid = 1'b1;
    tick();
    key = k2; rk_rd_en = 1'b1; rk_idx = 4'd3;
    tick();
    rk_rd_en = 1'b0;
    chk("rd_expand_err", {rk_rd_valid, rk_rd_err}, 2'b01);
    chk("rd_expand_hold", rk_data, exp_data);
    repeat (8) tick();
    key_valid = 1'b0;
    tick();
    chk("held_valid_ready", keys_valid, 1);
    model_expand(k1);
    read_all();
    read_err(4'd11, "rd_idx11_err");
    read_err(4'd15, "rd_idx15_err");
    tick();
    chk("err_one_cycle", {rk_rd_valid, rk_rd_err}, 2'b00);

    // New key accepted in READY alongside a read of idx 10: the old round key comes back.
    old10 = exp_rk[10];
    key = k2; key_valid = 1'b1; rk_rd_en = 1'b1; rk_idx = 4'd10;
    tick();
    key_valid = 1'b0; rk_rd_en = 1'b0;
    chk("simul_rd_data", rk_data, old10);
    chk("simul_flags", {rk_rd_valid, keys_valid, key_ready}, 3'b100);
    exp_data = old10;
    for (int c = 1; c <= 10; c++) begin
      tick();
      chk("simul_kv_timing", keys_valid, (c == 10) ? 1 : 0);
    end
    model_expand(k2);
    read_all();

    // Reset asserted on edge E5 of an expansion.
    key = rand128(); key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
    repeat (4) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("abort_flags", {key_ready, keys_valid, rk_rd_valid, rk_rd_err}, 4'b1000);
    chk("abort_data", rk_data, '0);
    exp_data = '0;
    repeat (12) tick();
    chk("abort_stays_idle", keys_valid, 0);
    read_err(4'd2, "abort_read_err");
    k1 = rand128();
    load_key(k1);
    read_all();

    for (int n = 0; n < 100; n++) begin
      load_key(rand128());
      read_all();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout vecs=%0d", vecs);
    $fatal(1, "watchdog");
  end

endmodule
